banked_mem_responder: RTL
=========================

# banked_mem_responder

Four-bank interleaved word memory responding to the cache FSM's memory-side requests (`mem_rd`, `mem_wr`, `mem_addr`, `mem_data_in`, `mem_DataOut`). Each bank serves one access, then stays busy for three further cycles. Read data returns two cycles after acceptance, which lets the cache controller stream a four-word line fill or write-back on consecutive cycles, one bank per cycle. The block is the responder end of the cache/memory interface and replaces any behavioural memory used under the cache in system simulation.

## Interface
- `ROW_BITS`, default 13: word rows per bank are 2^ROW_BITS; the row index is `Addr[15:3]`.
- `BUSY_CYCLES`, default 3: cycles a bank stays busy after accepting a request.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous reset, active-high.
- `Addr`, input, 16: byte address. Bank is `Addr[2:1]`, row is `Addr[15:3]`, and `Addr[0]` must be 0.
- `DataIn`, input, 16: write data.
- `Rd`, input, 1: read request.
- `Wr`, input, 1: write request.
- `DataOut`, output, 16: read data, valid only in the cycle `rd_valid` is 1; otherwise 0.
- `rd_valid`, output, 1: `DataOut` carries the result of a read accepted two cycles earlier.
- `stall`, output, 1, combinational: the current request targets a busy bank and is not accepted.
- `busy`, output, 4: per-bank busy flags, registered.
- `err`, output, 1, combinational: the current request is illegal and is not accepted.

## Operation
- **Request present:** `Rd|Wr` is 1.
- **err:** `err = !rst & ((Rd&Wr) | ((Rd|Wr)&Addr[0]))`.
- **stall:** `stall = !rst & !err & (Rd|Wr) & busy[Addr[2:1]]`.
- **accept:** `accept = !rst & (Rd^Wr) & !Addr[0] & !busy[Addr[2:1]]`.
- **Accepted write:** `bank[b][row]` gets `DataIn` at the end of the accept cycle. A read accepted on a later cycle returns the new value.
- **Accepted read:** the bank array is read at the accept cycle. Data is carried through a 2-stage pipeline (stage 1 holds data and valid, stage 2 drives `DataOut`/`rd_valid`).
- **Busy tracking:** each bank has a 2-bit down-counter. On accept it loads `BUSY_CYCLES`; otherwise it decrements while nonzero. `busy[b]` is high while the counter is nonzero.
- **Independence:** banks are independent. Back-to-back accepts to four different banks on four consecutive cycles are legal.
- **Rejected requests:** a stalled or erroring request changes no state. The initiator holds the request until `stall` drops.
- **Memory contents:** not initialised and not cleared by reset.

## Timing
- **Reset values (cycle after `rst`):**
  - `busy=4'b0000`, all counters 0.
  - Read pipeline valids 0, so `DataOut=16'h0000` and `rd_valid=0`.
  - While `rst=1`: `stall=0`, `err=0`, no accepts.
- **Read latency:** read accepted in cycle t gives `rd_valid=1` and `DataOut` = word in cycle t+2, for exactly one cycle.
- **Write latency:** write accepted in cycle t updates the array at the end of cycle t.
- **Bank occupancy:** accept to bank b in cycle t makes `busy[b]=1` in t+1..t+3. A new request to b is accepted at t+4.
- **Line streaming:** a 4-word line at offsets 0,2,4,6 issued in cycles t..t+3 is accepted with no stall. Read data returns in t+2..t+5.
- **Simultaneous events:**
  - A read completing on the output in the same cycle as a new accept: both proceed.
  - A counter reaching 0 in the same cycle as its bank is re-requested: that request is still stalled, because `busy` is registered.
- **Reset mid-operation:**
  - In-flight reads are discarded, so no `rd_valid` follows reset.
  - Busy counters are cleared.
  - A write accepted in the cycle before `rst` rises has completed. Nothing is accepted during `rst`.

## Test plan
- **Write then read:** after reset, write `16'hBEEF` to `Addr=16'h0010`. At t+4, read the same address. Require `rd_valid=1` and `DataOut=16'hBEEF` at t+6, with `stall=0` throughout.
- **Line stream:** write `16'h1111`, `16'h2222`, `16'h3333`, `16'h4444` to `16'h0400`, `16'h0402`, `16'h0404`, `16'h0406` on consecutive cycles; no stall. Then read the four back on consecutive cycles starting 4 cycles later. Require the data on 4 consecutive cycles, in order, beginning 2 cycles after the first read.
- **Bank conflict:** read `16'h0000` at t, then hold read `16'h0008` (same bank 0) from t+1. Require `stall=1` in t+1..t+3, acceptance at t+4, and `rd_valid` at t+6 only (no duplicate).
- **Errors:**
  - `Rd=Wr=1` gives `err=1`, `stall=0`, `busy` unchanged, no `rd_valid`.
  - `Wr=1` with `Addr=16'h0011` gives `err=1`, and a subsequent read of `16'h0010` returns its prior value.
- **Reset mid-read:** read accepted at t, `rst=1` at t+1. Require `rd_valid=0` and `DataOut=0` at t+2 and t+3, and `busy=0` the cycle after reset.
- **Reset during stall:** assert `rst` during a stall. Require `stall=0` while reset is high, and the held request accepted the first cycle after `rst` falls.

Source files
------------

// File: rtl/banked_mem_responder_if.sv
// Memory-side request/response bundle between the cache controller (master)
// and the banked memory responder (slave).
interface banked_mem_responder_if;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic [15:0] DataOut;
  logic        rd_valid;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  modport master (
    output Addr, DataIn, Rd, Wr,
    input  DataOut, rd_valid, stall, busy, err
  );

  modport slave (
    input  Addr, DataIn, Rd, Wr,
    output DataOut, rd_valid, stall, busy, err
  );
endinterface

// File: rtl/banked_mem_responder.sv
// Four-bank interleaved word memory: one access per bank, then the bank rests
// for BUSY_CYCLES cycles; reads return through a two-stage pipeline.
module banked_mem_responder #(
  parameter int ROW_BITS    = 13,
  parameter int BUSY_CYCLES = 3
) (
  input logic                  clk,
  input logic                  rst,
  banked_mem_responder_if.slave bus
);

  localparam int DEPTH = 4 * (2 ** ROW_BITS);

  logic [1:0]          bank;
  logic [ROW_BITS-1:0] row;
  logic                req;
  logic                err_c;
  logic                accept;
  logic [3:0]          busy_q;
  logic [1:0]          cnt [4];

  logic [15:0] mem [DEPTH];
  logic [15:0] s1_data;
  logic        s1_valid;
  logic [15:0] s2_data;
  logic        s2_valid;

  assign bank = bus.Addr[2:1];
  assign row  = bus.Addr[3 +: ROW_BITS];
  assign req  = bus.Rd | bus.Wr;

  always_comb begin
    busy_q = '0;
    for (int b = 0; b < 4; b++) busy_q[b] = (cnt[b] != 2'd0);
  end

  assign err_c  = !rst & ((bus.Rd & bus.Wr) | (req & bus.Addr[0]));
  assign accept = !rst & (bus.Rd ^ bus.Wr) & !bus.Addr[0] & !busy_q[bank];

  // Array and read capture carry no reset: contents survive reset by design.
  always_ff @(posedge clk) begin
    if (accept && bus.Wr) mem[{bank, row}] <= bus.DataIn;
    if (accept && bus.Rd) s1_data <= mem[{bank, row}];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      for (int b = 0; b < 4; b++) cnt[b] <= 2'd0;
    end else begin
      s1_valid <= accept & bus.Rd;
      s2_valid <= s1_valid;
      s2_data  <= s1_valid ? s1_data : 16'h0000;
      for (int b = 0; b < 4; b++) begin
        if (accept && (bank == 2'(b))) cnt[b] <= 2'(BUSY_CYCLES);
        else if (cnt[b] != 2'd0)       cnt[b] <= cnt[b] - 2'd1;
      end
    end
  end

  assign bus.err      = err_c;
  assign bus.stall    = !rst & !err_c & req & busy_q[bank];
  assign bus.busy     = busy_q;
  assign bus.rd_valid = s2_valid;
  assign bus.DataOut  = s2_data;

endmodule
